// File: rtl/ysyx_24080006_icache_ctrl.sv
// rtl/ysyx_24080006_icache_ctrl.sv - I-cache controller: lookup, AXI4 burst refill, fence.i flush
// Optional macro ICACHE_PERF_EN adds perf_hit/perf_miss counters.
module ysyx_24080006_icache_ctrl #(
    parameter int IC_N   = 4,
    parameter int IC_M   = 2,
    parameter int TAG_W  = 32 - IC_N - IC_M - 2,
    parameter int LINE_W = 1 + TAG_W + 32 * (2 ** IC_M)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_valid,
    output logic              ifu_ready,
    input  logic [31:0]       ifu_addr,
    output logic              rsp_valid,
    output logic [31:0]       rsp_inst,
    output logic              rsp_err,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [IC_N-1:0]   ic_index,
    input  logic [LINE_W-1:0] ic_rdata,
    output logic              ic_we,
    output logic [LINE_W-1:0] ic_wdata,
    output logic [31:0]       araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
`endif
);

    localparam int WORDS  = 2 ** IC_M;
    localparam int DATA_W = 32 * WORDS;
    localparam logic [IC_M:0] BEAT_MAX = (IC_M + 1)'(WORDS);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, REFILL, FLUSH} state_t;

    state_t            state;
    logic [31:0]       req_addr;
    logic [IC_N-1:0]   flush_cnt;
    logic [IC_M:0]     beat;
    logic              flush_pend;
    logic              err;
    logic [31:0]       line_buf [WORDS];
    logic [31:0]       arr_words [WORDS];
    logic [DATA_W-1:0] line_data;
    logic [IC_N-1:0]   req_index;
    logic [IC_M-1:0]   req_word;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;

    assign req_index = req_addr[IC_M+1+IC_N:IC_M+2];
    assign req_word  = req_addr[IC_M+1:2];
    assign req_tag   = req_addr[31:32-TAG_W];
    assign hit       = ic_rdata[LINE_W-1] && (ic_rdata[LINE_W-2 -: TAG_W] == req_tag);

    always_comb begin
        line_data = '0;
        for (int i = 0; i < WORDS; i++) begin
            arr_words[i]          = ic_rdata[i*32 +: 32];
            line_data[i*32 +: 32] = line_buf[i];
        end
    end

    assign ifu_ready = (state == IDLE) && !flush_pend && !flush_req;
    assign rready    = (state == MISS_R);
    assign ic_index  = (state == FLUSH) ? flush_cnt : req_index;
    // An errored refill never reaches the array, so the line stays invalid.
    assign ic_we     = (state == FLUSH) || ((state == REFILL) && !err);
    assign ic_wdata  = (state == REFILL) ? {1'b1, req_tag, line_data} : '0;
    assign arlen     = 8'(WORDS - 1);
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_addr   <= '0;
            flush_cnt  <= '0;
            beat       <= '0;
            flush_pend <= 1'b0;
            err        <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_inst   <= '0;
            rsp_err    <= 1'b0;
            flush_done <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            for (int i = 0; i < WORDS; i++) line_buf[i] <= '0;
`ifdef ICACHE_PERF_EN
            perf_hit   <= '0;
            perf_miss  <= '0;
`endif
        end else begin
            rsp_valid  <= 1'b0;
            flush_done <= 1'b0;
            if (flush_req && (state inside {LOOKUP, MISS_AR, MISS_R, REFILL}))
                flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_req || flush_pend) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end else if (ifu_valid) begin
                        req_addr <= ifu_addr;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        rsp_valid <= 1'b1;
                        rsp_inst  <= arr_words[req_word];
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
`ifdef ICACHE_PERF_EN
                        perf_hit  <= perf_hit + 32'd1;
`endif
                    end else begin
                        araddr    <= {req_addr[31:IC_M+2], (IC_M + 2)'(0)};
                        arvalid   <= 1'b1;
                        state     <= MISS_AR;
`ifdef ICACHE_PERF_EN
                        perf_miss <= perf_miss + 32'd1;
`endif
                    end
                end
                MISS_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        beat    <= '0;
                        err     <= 1'b0;
                        state   <= MISS_R;
                    end
                end
                MISS_R: begin
                    if (rvalid) begin
                        if (beat < BEAT_MAX) begin
                            line_buf[beat[IC_M-1:0]] <= rdata;
                            beat                     <= beat + (IC_M + 1)'(1);
                        end
                        if (rresp != 2'b00) err <= 1'b1;
                        if (rlast) state <= REFILL;
                    end
                end
                REFILL: begin
                    rsp_valid <= 1'b1;
                    rsp_inst  <= err ? 32'd0 : line_buf[req_word];
                    rsp_err   <= err;
                    state     <= IDLE;
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + IC_N'(1);
                    if (flush_cnt == '1) begin
                        flush_done <= 1'b1;
                        flush_pend <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_24080006_icache_ctrl.md
Name: ysyx_24080006_icache_ctrl

Overview:
- Controller stage in front of the register-based I-cache array. It consumes array read data and produces array write commands.
- Accepts fetch requests from the IFU, indexes the array, and compares tag and valid bit.
- On a hit it returns the instruction word. On a miss it refills the full line through an AXI4 INCR burst read, writes it into the array, then responds.
- Also executes a fence.i flush by walking every index and clearing it.

Parameters:
- IC_N, 4, index bits; the array has 2^IC_N lines.
- IC_M, 2, word-offset bits; each line holds 2^IC_M 32-bit words.
- TAG_W, 32-IC_N-IC_M-2, tag width.
- LINE_W, 1+TAG_W+32*2^IC_M, array entry width, packed as {valid, tag, data}. Word k of the line is data[32k+31:32k].

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset; 0 = asserted
- ifu_valid  in  1  fetch request valid
- ifu_ready  out  1  controller can accept a request
- ifu_addr  in  32  fetch byte address; bits [1:0] ignored
- rsp_valid  out  1  one-cycle response pulse
- rsp_inst  out  32  returned instruction
- rsp_err  out  1  refill bus error
- flush_req  in  1  fence.i invalidate request (level or pulse)
- flush_done  out  1  one-cycle pulse when the flush completes
- ic_index  out  IC_N  array index
- ic_rdata  in  LINE_W  combinational array read of ic_index
- ic_we  out  1  array write enable
- ic_wdata  out  LINE_W  array write data
- araddr  out  32  AXI read address
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- arlen  out  8  constant 2^IC_M-1
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- rdata  in  32  AXI read data
- rresp  in  2  AXI read response
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready

Behaviour:
- Reset values:
  - state = IDLE.
  - ifu_ready=1 (combinational: high only in IDLE with no flush pending).
  - rsp_valid=0, rsp_inst=0, rsp_err=0, flush_done=0.
  - ic_we=0, arvalid=0, rready=0, araddr=0, beat counter=0, flush pending=0.
- Reset mid-operation: everything returns to IDLE immediately. An outstanding AXI burst is abandoned; the system resets the bus together with the controller.
- Address split: index = addr[IC_M+1+IC_N:IC_M+2], word = addr[IC_M+1:2], tag = addr[31:32-TAG_W].
- ic_index is driven from the latched request address, except in FLUSH, where it comes from the flush counter.
- IDLE:
  - flush_req=1 or a pending flush has priority: go to FLUSH with the counter at 0, and ifu_ready=0.
  - Otherwise, on ifu_valid&ifu_ready: latch ifu_addr and go to LOOKUP.
- LOOKUP:
  - Hit = ic_rdata valid bit is 1 and ic_rdata tag equals the latched tag.
  - Hit: register rsp_inst from the selected word, rsp_valid=1 next cycle, go to IDLE. Hit latency is 2 cycles (accepted at T, rsp_valid at T+2).
  - Miss: araddr = line-aligned address (low IC_M+2 bits zero), arvalid=1, go to MISS_AR.
- MISS_AR: hold arvalid and araddr stable until arready, then go to MISS_R with the beat counter at 0.
- MISS_R:
  - rready=1. On each rvalid beat, store rdata into line-buffer word[beat] and increment beat.
  - Any rresp != 2'b00 sets a sticky error flag.
  - On a beat with rlast=1, go to REFILL. Beats after 2^IC_M are ignored.
- REFILL:
  - No error: ic_we=1 for one cycle with ic_wdata = {1, tag, line buffer}.
  - Error: ic_we stays 0.
  - Next cycle: rsp_valid=1; rsp_inst = buffered requested word (0 on error); rsp_err = error flag. Then go to IDLE.
- Response rules:
  - rsp_valid is high exactly one cycle; there is no backpressure.
  - rsp_err is 0 on all hit responses.
- FLUSH:
  - Each cycle: ic_we=1, ic_wdata=0, ic_index=counter, counter+1.
  - After index 2^IC_N-1 is written: flush_done=1 for one cycle, clear pending, go to IDLE. Flush takes 2^IC_N cycles.
- Flush during a busy state: a flush_req seen in LOOKUP, MISS_AR, MISS_R or REFILL sets the pending bit. The current access completes first, including its array write.
- Simultaneous flush_req and ifu_valid in IDLE: the flush wins and the request is not accepted.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined, two extra output ports exist:
  - perf_hit 32: counts LOOKUP hits.
  - perf_miss 32: counts LOOKUP misses.
- Both reset to 0, wrap modulo 2^32, and are not cleared by flush.
- When not defined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Cold miss: after reset, request 0x8000_0014 with AXI returning 0x11,0x22,0x33,0x44 -> araddr=0x8000_0010 with arlen=3, ic_we written {1, tag, data}, and rsp_inst=0x22 with rsp_err=0.
- Hit: request 0x8000_001C next -> no arvalid, and rsp_inst=0x44 two cycles after acceptance.
- Conflict: request 0x8000_0410 (same index 1, different tag) -> miss with refill, then re-request 0x8000_0010 -> miss again.
- Bus error: rresp=2'b10 on beat 2 -> ic_we never asserted, rsp_err=1, rsp_inst=0, and a repeat request misses.
- Flush: flush_req asserted during MISS_R -> refill completes and responds, then 16 cycles of ic_we with wdata=0 and indices 0..15, then flush_done; a subsequent hit address misses.
- Reset: drive reset=0 while in MISS_AR -> arvalid=0 and ifu_ready=1 immediately; with ICACHE_PERF_EN defined, perf_hit=perf_miss=0.
